// File: rtl/bp_update_queue.sv
// Commit-order FIFO between the ROB commit stage and the gshare update port.
// Optional performance counters are enabled by defining BPQ_PERF_CNT_EN.
module bp_update_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CMT_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CMT_WIDTH-1:0]    in_valid,
   input  logic [CMT_WIDTH*32-1:0] in_pc,
   input  logic [CMT_WIDTH-1:0]    in_taken,
   output logic                    in_ready,
   output logic                    out_update_en,
   output logic [31:0]             out_pc,
   output logic                    out_branch_taken,
   input  logic                    out_ready
`ifdef BPQ_PERF_CNT_EN
   ,
   output logic [31:0]             perf_updates,
   output logic [31:0]             perf_stall_cycles
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - CMT_WIDTH);

   logic [31:0]      mem_pc [DEPTH];
   logic [DEPTH-1:0] mem_taken;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   logic             enq;
   logic             deq;
   logic [CNT_W-1:0] enq_cnt;
   logic [PTR_W-1:0] wr_idx [CMT_WIDTH];

   // Each valid lane lands at tail plus the number of valid lanes older than it.
   always_comb begin
      enq_cnt = '0;
      for (int i = 0; i < CMT_WIDTH; i++) begin
         wr_idx[i] = tail_q + PTR_W'(enq_cnt);
         if (in_valid[i]) begin
            enq_cnt = enq_cnt + CNT_W'(1);
         end
      end
   end

   // Ready looks only at the registered count so it never depends on out_ready.
   assign in_ready         = (count_q <= READY_MAX);
   assign enq              = in_ready && (|in_valid);
   assign out_update_en    = (count_q != '0);
   assign deq              = out_update_en && out_ready;
   assign out_pc           = mem_pc[head_q];
   assign out_branch_taken = mem_taken[head_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i] <= '0;
         end
         mem_taken <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         if (enq) begin
            for (int i = 0; i < CMT_WIDTH; i++) begin
               if (in_valid[i]) begin
                  mem_pc[wr_idx[i]]    <= in_pc[i*32 +: 32];
                  mem_taken[wr_idx[i]] <= in_taken[i];
               end
            end
            tail_q <= tail_q + PTR_W'(enq_cnt);
         end
         if (deq) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_q + (enq ? enq_cnt : CNT_W'(0)) - (deq ? CNT_W'(1) : CNT_W'(0));
      end
   end

`ifdef BPQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_updates      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (deq && (perf_updates != '1)) begin
            perf_updates <= perf_updates + 32'd1;
         end
         if ((|in_valid) && !in_ready && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based model.
module tb_bp_update_queue;

   localparam int DEPTH     = 8;
   localparam int CMT_WIDTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid;
   logic [63:0] in_pc;
   logic [1:0]  in_taken;
   logic        in_ready;
   logic        out_update_en;
   logic [31:0] out_pc;
   logic        out_branch_taken;
   logic        out_ready;
`ifdef BPQ_PERF_CNT_EN
   logic [31:0] perf_updates;
   logic [31:0] perf_stall_cycles;
   int unsigned m_updates;
   int unsigned m_stalls;
`endif

   bp_update_queue #(
      .DEPTH     (DEPTH),
      .CMT_WIDTH (CMT_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_pc            (in_pc),
      .in_taken         (in_taken),
      .in_ready         (in_ready),
      .out_update_en    (out_update_en),
      .out_pc           (out_pc),
      .out_branch_taken (out_branch_taken),
      .out_ready        (out_ready)
`ifdef BPQ_PERF_CNT_EN
      ,
      .perf_updates      (perf_updates),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: FIFO of {pc, taken} in commit order.
   logic [32:0] mq[$];

   typedef struct {
      logic [1:0]  v;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [1:0]  t;
      logic        ordy;
      logic        e_rdy;
      logic        e_en;
      logic [31:0] e_pc;
      logic        e_tk;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] t, input logic ordy);
      in_valid  = v;
      in_pc     = {p1, p0};
      in_taken  = t;
      out_ready = ordy;
   endtask

   task automatic check_model();
      chk("model_in_ready", 32'(in_ready), 32'((DEPTH - mq.size()) >= CMT_WIDTH));
      chk("model_update_en", 32'(out_update_en), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("model_pc", out_pc, mq[0][32:1]);
         chk("model_taken", 32'(out_branch_taken), 32'(mq[0][0]));
      end
`ifdef BPQ_PERF_CNT_EN
      chk("model_perf_updates", perf_updates, m_updates);
      chk("model_perf_stalls", perf_stall_cycles, m_stalls);
`endif
   endtask

   // Check current outputs, clock once, then advance the model with what was driven.
   task automatic tick();
      bit rdy;
      check_model();
      @(posedge clk);
      if (rst) begin
         mq.delete();
`ifdef BPQ_PERF_CNT_EN
         m_updates = 0;
         m_stalls  = 0;
`endif
      end else begin
         rdy = (DEPTH - mq.size()) >= CMT_WIDTH;
`ifdef BPQ_PERF_CNT_EN
         if (mq.size() != 0 && out_ready) m_updates++;
         if ((in_valid != 2'b00) && !rdy) m_stalls++;
`endif
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (rdy) begin
            for (int i = 0; i < CMT_WIDTH; i++) begin
               if (in_valid[i]) mq.push_back({in_pc[i*32 +: 32], in_taken[i]});
            end
         end
      end
      #1;
   endtask

   task automatic pulse_reset();
      drive(2'b00, 0, 0, 2'b00, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Directed pair, lane-gap entry; expectations hold before each edge.
      tbl[0] = '{2'b11, 32'h1000, 32'h1004, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0};
      tbl[1] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1};
      tbl[2] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b1, 1'b1, 1'b1, 32'h1004, 1'b0};
      tbl[3] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0};
      tbl[4] = '{2'b10, 32'hdead, 32'h2008, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0};
      tbl[5] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b0, 1'b1, 1'b1, 32'h2008, 1'b1};
      tbl[6] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b1, 1'b1, 1'b1, 32'h2008, 1'b1};
      tbl[7] = '{2'b00, 32'h0,    32'h0,    2'b00, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0};

      rst = 1'b1;
      drive(2'b00, 0, 0, 2'b00, 1'b0);
`ifdef BPQ_PERF_CNT_EN
      m_updates = 0;
      m_stalls  = 0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_update_en", 32'(out_update_en), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_pc", out_pc, 32'd0);
      chk("reset_taken", 32'(out_branch_taken), 32'd0);

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].p0, tbl[i].p1, tbl[i].t, tbl[i].ordy);
         chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
         chk("tbl_update_en", 32'(out_update_en), 32'(tbl[i].e_en));
         if (tbl[i].e_en) begin
            chk("tbl_pc", out_pc, tbl[i].e_pc);
            chk("tbl_taken", 32'(out_branch_taken), 32'(tbl[i].e_tk));
         end
         tick();
      end

      // Fill to full with the consumer stalled; a fifth pair must be held off.
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 32'h4000 + 8 * k, 32'h4004 + 8 * k, 2'(k), 1'b0);
         tick();
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drive(2'b11, 32'h5000, 32'h5004, 2'b11, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(2'b00, 0, 0, 2'b00, 1'b1);
         chk("fill_drain_pc", out_pc, 32'h4000 + 4 * i);
         tick();
      end
      chk("fill_drain_empty", 32'(out_update_en), 32'd0);

      // Move head/tail to entry 7, then a pair must straddle the wrap.
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         drive(2'b01, 32'h100 + i, 0, 2'b00, 1'b1);
         tick();
      end
      drive(2'b00, 0, 0, 2'b00, 1'b1);
      tick();
      drive(2'b11, 32'h3000, 32'h3004, 2'b10, 1'b0);
      tick();
      drive(2'b00, 0, 0, 2'b00, 1'b1);
      chk("wrap_pc0", out_pc, 32'h3000);
      chk("wrap_tk0", 32'(out_branch_taken), 32'd0);
      tick();
      chk("wrap_pc1", out_pc, 32'h3004);
      chk("wrap_tk1", 32'(out_branch_taken), 32'd1);
      tick();
      chk("wrap_empty", 32'(out_update_en), 32'd0);

      // Count 6, enqueue 2 while dequeuing 1 -> 7, which is near-full.
      pulse_reset();
      for (int k = 0; k < 3; k++) begin
         drive(2'b11, 32'h6000 + 8 * k, 32'h6004 + 8 * k, 2'b01, 1'b0);
         tick();
      end
      drive(2'b11, 32'h6100, 32'h6104, 2'b11, 1'b1);
      tick();
      drive(2'b01, 32'h6200, 0, 2'b01, 1'b0);
      chk("near_full_in_ready", 32'(in_ready), 32'd0);
      chk("near_full_en", 32'(out_update_en), 32'd1);
      tick();

      // Reset with five entries buffered discards them all.
      pulse_reset();
      drive(2'b11, 32'h7000, 32'h7004, 2'b00, 1'b0);
      tick();
      tick();
      drive(2'b01, 32'h7010, 0, 2'b00, 1'b0);
      tick();
      chk("pre_reset_en", 32'(out_update_en), 32'd1);
      pulse_reset();
      chk("post_reset_en", 32'(out_update_en), 32'd0);
      chk("post_reset_ready", 32'(in_ready), 32'd1);

      // Randomized traffic with bursts of consumer backpressure and rare resets.
      for (int n = 0; n < 3000; n++) begin
         drive(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
               ((n / 64) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      drive(2'b00, 0, 0, 2'b00, 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) tick();
      chk("final_empty", 32'(out_update_en), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
